// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB with
// valid/ack handshakes, decodes RV64I (or RV32I), counts retired
// instructions and halts on ebreak, illegal instruction or bus timeout.
module multicycle_ctrl #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifetch_req,
  input  logic             ifetch_ack,
  input  logic [31:0]      ifetch_data,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [1:0]       dmem_size,
  output logic             dmem_unsigned,
  input  logic             dmem_ack,
  input  logic             br_taken,
  output logic [31:0]      ir,
  output logic [3:0]       alu_op,
  output logic             word_op,
  output logic [2:0]       ext_op,
  output logic             alu_a_sel,
  output logic [1:0]       alu_b_sel,
  output logic             wb_sel,
  output logic [1:0]       branch,
  output logic             reg_wr,
  output logic             pc_wr,
  output logic             pc_sel,
  output logic             halt,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam bit          RV64  = (XLEN == 64);

  localparam logic [1:0] CAUSE_EBREAK  = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         cause_nxt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               br_q;
  logic               illegal;
  logic               is_ebreak;
  logic               is_mem;
  logic               wr_en;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opcode = ir[6:0];
  assign f3     = ir[14:12];
  assign f7     = ir[31:25];

  // Map funct3 (plus the alternate bit ir[30]) to the ALU operation code.
  function automatic logic [3:0] f3_op(input logic [2:0] fn, input logic alt);
    case (fn)
      3'd0:    f3_op = alt ? 4'd2 : 4'd0;
      3'd1:    f3_op = 4'd3;
      3'd2:    f3_op = 4'd9;
      3'd3:    f3_op = 4'd10;
      3'd4:    f3_op = 4'd6;
      3'd5:    f3_op = alt ? 4'd5 : 4'd4;
      3'd6:    f3_op = 4'd7;
      default: f3_op = 4'd8;
    endcase
  endfunction

  // Combinational instruction decode from the latched instruction.
  always_comb begin
    alu_op        = 4'd0;
    word_op       = 1'b0;
    ext_op        = 3'd0;
    alu_a_sel     = 1'b1;
    alu_b_sel     = 2'd0;
    wb_sel        = 1'b0;
    branch        = 2'd0;
    dmem_we       = 1'b0;
    dmem_size     = ir[13:12];
    dmem_unsigned = 1'b0;
    illegal       = 1'b0;
    is_ebreak     = 1'b0;
    is_mem        = 1'b0;
    wr_en         = 1'b0;
    case (opcode)
      7'b0110111: begin // lui
        alu_op = 4'd1; ext_op = 3'd5; wr_en = 1'b1;
      end
      7'b0010111: begin // auipc
        alu_a_sel = 1'b0; ext_op = 3'd5; wr_en = 1'b1;
      end
      7'b1101111: begin // jal: ALU forms the link PC+4
        alu_a_sel = 1'b0; alu_b_sel = 2'd2; ext_op = 3'd6;
        branch = 2'd1; wr_en = 1'b1;
      end
      7'b1100111: begin // jalr
        alu_a_sel = 1'b0; alu_b_sel = 2'd2; ext_op = 3'd2;
        branch = 2'd2; wr_en = 1'b1;
        if (f3 != 3'd0) illegal = 1'b1;
      end
      7'b1100011: begin // conditional branch; comparison is external
        alu_op = 4'd2; alu_b_sel = 2'd1; ext_op = 3'd4; branch = 2'd3;
        if (f3 == 3'd2 || f3 == 3'd3) illegal = 1'b1;
      end
      7'b0000011: begin // loads
        ext_op = 3'd2; wb_sel = 1'b1; is_mem = 1'b1; wr_en = 1'b1;
        dmem_unsigned = ir[14];
        if (f3 == 3'd7 || ((f3 == 3'd3 || f3 == 3'd6) && !RV64)) illegal = 1'b1;
      end
      7'b0100011: begin // stores
        ext_op = 3'd3; dmem_we = 1'b1; is_mem = 1'b1;
        if (f3[2] || (f3 == 3'd3 && !RV64)) illegal = 1'b1;
      end
      7'b0010011: begin // op-imm; shifts carry a 6-bit shamt on RV64
        ext_op = 3'd2; wr_en = 1'b1;
        alu_op = f3_op(f3, (f3 == 3'd5) && ir[30]);
        if (f3 == 3'd1 &&
            (ir[31:26] != 6'b000000 || (!RV64 && ir[25]))) illegal = 1'b1;
        if (f3 == 3'd5 &&
            ((ir[31:26] != 6'b000000 && ir[31:26] != 6'b010000) ||
             (!RV64 && ir[25]))) illegal = 1'b1;
      end
      7'b0011011: begin // op-imm-32 (*W immediates)
        ext_op = 3'd2; wr_en = 1'b1; word_op = 1'b1;
        alu_op = f3_op(f3, (f3 == 3'd5) && ir[30]);
        case (f3)
          3'd0:    ;
          3'd1:    if (f7 != 7'b0000000) illegal = 1'b1;
          3'd5:    if (f7 != 7'b0000000 && f7 != 7'b0100000) illegal = 1'b1;
          default: illegal = 1'b1;
        endcase
        if (!RV64) illegal = 1'b1;
      end
      7'b0110011: begin // register-register
        ext_op = 3'd1; alu_b_sel = 2'd1; wr_en = 1'b1;
        alu_op = f3_op(f3, ir[30]);
        if (!(f7 == 7'b0000000 ||
              (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)))) illegal = 1'b1;
      end
      7'b0111011: begin // op-32 (*W register ops)
        ext_op = 3'd1; alu_b_sel = 2'd1; wr_en = 1'b1; word_op = 1'b1;
        alu_op = f3_op(f3, ir[30]);
        if (!((f7 == 7'b0000000 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) ||
              (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)))) illegal = 1'b1;
        if (!RV64) illegal = 1'b1;
      end
      7'b0001111: begin // fence / fence.i as no-ops
        if (f3[2:1] != 2'b00) illegal = 1'b1;
      end
      7'b1110011: begin // ecall is a no-op, ebreak halts
        if (ir == 32'h0010_0073)      is_ebreak = 1'b1;
        else if (ir != 32'h0000_0073) illegal   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Next-state logic, including the halt cause captured on entry to HALT.
  always_comb begin
    state_nxt = state;
    cause_nxt = CAUSE_EBREAK;
    case (state)
      S_FETCH: begin
        if (ifetch_ack) state_nxt = S_DECODE;
        else if (tmo_cnt == TMO_W'(TIMEOUT)) begin
          state_nxt = S_HALT; cause_nxt = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          state_nxt = S_HALT; cause_nxt = CAUSE_ILLEGAL;
        end else if (is_ebreak) begin
          state_nxt = S_HALT; cause_nxt = CAUSE_EBREAK;
        end else state_nxt = S_EXEC;
      end
      S_EXEC: state_nxt = is_mem ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack) state_nxt = S_WB;
        else if (tmo_cnt == TMO_W'(TIMEOUT)) begin
          state_nxt = S_HALT; cause_nxt = CAUSE_TIMEOUT;
        end
      end
      S_WB:    state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  // Requests and strobes; requests drop asynchronously while in reset.
  always_comb begin
    ifetch_req = (state == S_FETCH) && !rst;
    dmem_req   = (state == S_MEM) && !rst;
    reg_wr     = (state == S_WB) && wr_en;
    pc_wr      = (state == S_WB);
    pc_sel     = (state == S_WB) &&
                 (branch == 2'd1 || branch == 2'd2 || (branch == 2'd3 && br_q));
    halt       = (state == S_HALT);
  end

  // Instruction register, retire counter, timeout counter, branch latch, halt cause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir         <= '0;
      instret    <= '0;
      tmo_cnt    <= '0;
      br_q       <= 1'b0;
      halt_cause <= CAUSE_EBREAK;
    end else begin
      if (state == S_FETCH && ifetch_ack) ir <= ifetch_data;
      if (state == S_WB) instret <= instret + CNT_W'(1);
      if (state == S_EXEC && branch == 2'd3) br_q <= br_taken;
      if (state_nxt != state) tmo_cnt <= '0;
      else if ((state == S_FETCH && !ifetch_ack) || (state == S_MEM && !dmem_ack))
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (state_nxt == S_HALT && state != S_HALT) halt_cause <= cause_nxt;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: an RV64 instance (TIMEOUT = 4) and an
// RV32 instance sharing the same stimulus. Inputs change and outputs are
// sampled just after the falling edge.
module tb_multicycle_ctrl;

  localparam logic [31:0] I_ADDI   = 32'h0050_0093;
  localparam logic [31:0] I_LD     = 32'h0080_B103;
  localparam logic [31:0] I_BEQ    = 32'h0020_8463;
  localparam logic [31:0] I_ADDW   = 32'h0020_80BB;
  localparam logic [31:0] I_SLLI32 = 32'h0200_9093;
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;
  localparam logic [31:0] I_ECALL  = 32'h0000_0073;
  localparam logic [31:0] I_ZERO   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifetch_ack = 1'b0;
  logic [31:0] ifetch_data = '0;
  logic        dmem_ack = 1'b0;
  logic        br_taken = 1'b0;

  logic        ifetch_req, dmem_req, dmem_we, dmem_unsigned;
  logic [1:0]  dmem_size;
  logic [31:0] ir;
  logic [3:0]  alu_op;
  logic        word_op, alu_a_sel, wb_sel, reg_wr, pc_wr, pc_sel, halt;
  logic [2:0]  ext_op;
  logic [1:0]  alu_b_sel, branch, halt_cause;
  logic [31:0] instret;

  logic        n_ifetch_req, n_dmem_req, n_dmem_we, n_dmem_unsigned;
  logic [1:0]  n_dmem_size;
  logic [31:0] n_ir;
  logic [3:0]  n_alu_op;
  logic        n_word_op, n_alu_a_sel, n_wb_sel, n_reg_wr, n_pc_wr, n_pc_sel, n_halt;
  logic [2:0]  n_ext_op;
  logic [1:0]  n_alu_b_sel, n_branch, n_halt_cause;
  logic [31:0] n_instret;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.XLEN(64), .TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifetch_req(ifetch_req), .ifetch_ack(ifetch_ack), .ifetch_data(ifetch_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_size(dmem_size),
    .dmem_unsigned(dmem_unsigned), .dmem_ack(dmem_ack), .br_taken(br_taken),
    .ir(ir), .alu_op(alu_op), .word_op(word_op), .ext_op(ext_op),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .wb_sel(wb_sel),
    .branch(branch), .reg_wr(reg_wr), .pc_wr(pc_wr), .pc_sel(pc_sel),
    .halt(halt), .halt_cause(halt_cause), .instret(instret)
  );

  multicycle_ctrl #(.XLEN(32), .TIMEOUT(4), .CNT_W(32)) dut32 (
    .clk(clk), .rst(rst),
    .ifetch_req(n_ifetch_req), .ifetch_ack(ifetch_ack), .ifetch_data(ifetch_data),
    .dmem_req(n_dmem_req), .dmem_we(n_dmem_we), .dmem_size(n_dmem_size),
    .dmem_unsigned(n_dmem_unsigned), .dmem_ack(dmem_ack), .br_taken(br_taken),
    .ir(n_ir), .alu_op(n_alu_op), .word_op(n_word_op), .ext_op(n_ext_op),
    .alu_a_sel(n_alu_a_sel), .alu_b_sel(n_alu_b_sel), .wb_sel(n_wb_sel),
    .branch(n_branch), .reg_wr(n_reg_wr), .pc_wr(n_pc_wr), .pc_sel(n_pc_sel),
    .halt(n_halt), .halt_cause(n_halt_cause), .instret(n_instret)
  );

  // Reset both instances; returns at the falling edge that starts FETCH cycle 0.
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; ifetch_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0; ifetch_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Fetch one instruction with an immediate ack in the current FETCH cycle,
  // then run through DECODE, EXEC, WB; returns at the next FETCH cycle.
  task automatic run_simple(input logic [31:0] instr);
    ifetch_ack = 1'b1; ifetch_data = instr;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ifetch_ack = 1'b0;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; ifetch_ack = 1'b1; ifetch_data = I_ADDI;
    #1;
    checks++; if (ifetch_req !== 1'b0) begin errors++; $display("FAIL reset_ifetch_req: got %b exp 0", ifetch_req); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_dmem_req: got %b exp 0", dmem_req); end
    @(negedge clk); #1;
    checks++; if (ir !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h exp 0", ir); end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret: got %0d exp 0", instret); end
    checks++; if ({halt, halt_cause} !== 3'b000) begin errors++; $display("FAIL reset_halt: got %b exp 000", {halt, halt_cause}); end
    checks++; if ({reg_wr, pc_wr} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b exp 00", {reg_wr, pc_wr}); end
    @(negedge clk);
    rst = 1'b0; ifetch_ack = 1'b0;
    #1;
    checks++; if (ifetch_req !== 1'b1) begin errors++; $display("FAIL reset_release_req: got %b exp 1", ifetch_req); end
  endtask

  task automatic test_addi;
    do_reset();
    ifetch_ack = 1'b1; ifetch_data = I_ADDI; #1;
    checks++; if (ifetch_req !== 1'b1) begin errors++; $display("FAIL addi_c0_req: got %b exp 1", ifetch_req); end
    @(negedge clk); ifetch_ack = 1'b0; dmem_ack = 1'b1; #1;
    checks++; if (ir !== I_ADDI) begin errors++; $display("FAIL addi_ir: got %h exp %h", ir, I_ADDI); end
    checks++; if ({alu_op, ext_op, alu_a_sel, alu_b_sel} !== {4'd0, 3'd2, 1'b1, 2'd0})
      begin errors++; $display("FAIL addi_decode: got op=%0d ext=%0d a=%0d b=%0d exp 0 2 1 0", alu_op, ext_op, alu_a_sel, alu_b_sel); end
    checks++; if (ifetch_req !== 1'b0) begin errors++; $display("FAIL addi_decode_req: got %b exp 0", ifetch_req); end
    @(negedge clk); dmem_ack = 1'b0; #1;
    checks++; if ({dmem_req, reg_wr, pc_wr} !== 3'b000) begin errors++; $display("FAIL addi_exec: got %b exp 000", {dmem_req, reg_wr, pc_wr}); end
    @(negedge clk); #1;
    checks++; if ({reg_wr, pc_wr, pc_sel, wb_sel} !== 4'b1100) begin errors++; $display("FAIL addi_wb: got %b exp 1100", {reg_wr, pc_wr, pc_sel, wb_sel}); end
    @(negedge clk); #1;
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL addi_instret: got %0d exp 1", instret); end
    checks++; if ({ifetch_req, reg_wr, pc_wr} !== 3'b100) begin errors++; $display("FAIL addi_refetch: got %b exp 100", {ifetch_req, reg_wr, pc_wr}); end
  endtask

  task automatic test_load;
    do_reset();
    ifetch_ack = 1'b1; ifetch_data = I_LD;
    @(negedge clk); ifetch_ack = 1'b0;
    @(negedge clk); #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL ld_exec_req: got %b exp 0", dmem_req); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); dmem_ack = (i == 3); #1;
      checks++; if ({dmem_req, dmem_size, dmem_we, dmem_unsigned} !== 5'b11100)
        begin errors++; $display("FAIL ld_mem%0d: got req/size/we/uns %b exp 11100", i, {dmem_req, dmem_size, dmem_we, dmem_unsigned}); end
    end
    @(negedge clk); dmem_ack = 1'b0; #1;
    checks++; if ({dmem_req, wb_sel, reg_wr, pc_wr} !== 4'b0111) begin errors++; $display("FAIL ld_wb: got %b exp 0111", {dmem_req, wb_sel, reg_wr, pc_wr}); end
    @(negedge clk); #1;
    checks++; if ({ifetch_req, instret} !== {1'b1, 32'd1}) begin errors++; $display("FAIL ld_8cycles: got req=%b instret=%0d exp 1 1", ifetch_req, instret); end
  endtask

  task automatic test_branch;
    do_reset();
    ifetch_ack = 1'b1; ifetch_data = I_BEQ;
    @(negedge clk); ifetch_ack = 1'b0; #1;
    checks++; if ({branch, ext_op} !== {2'd3, 3'd4}) begin errors++; $display("FAIL beq_decode: got br=%0d ext=%0d exp 3 4", branch, ext_op); end
    @(negedge clk); br_taken = 1'b1;
    @(negedge clk); br_taken = 1'b0; #1;
    checks++; if ({pc_wr, pc_sel, reg_wr} !== 3'b110) begin errors++; $display("FAIL beq_taken: got wr/sel/rw %b exp 110", {pc_wr, pc_sel, reg_wr}); end
    @(negedge clk);
    ifetch_ack = 1'b1; ifetch_data = I_BEQ;
    @(negedge clk); ifetch_ack = 1'b0;
    @(negedge clk); br_taken = 1'b0;
    @(negedge clk); br_taken = 1'b1; #1;
    checks++; if ({pc_wr, pc_sel, reg_wr} !== 3'b100) begin errors++; $display("FAIL beq_not_taken: got wr/sel/rw %b exp 100", {pc_wr, pc_sel, reg_wr}); end
    @(negedge clk); br_taken = 1'b0; #1;
    checks++; if (instret !== 32'd2) begin errors++; $display("FAIL beq_instret: got %0d exp 2", instret); end
  endtask

  task automatic test_word_ops;
    do_reset();
    ifetch_ack = 1'b1; ifetch_data = I_ADDW;
    @(negedge clk); ifetch_ack = 1'b0; #1;
    checks++; if ({word_op, alu_op, ext_op} !== {1'b1, 4'd0, 3'd1}) begin errors++; $display("FAIL addw_decode: got w=%b op=%0d ext=%0d exp 1 0 1", word_op, alu_op, ext_op); end
    @(negedge clk); #1;
    checks++; if ({n_halt, n_halt_cause, n_ifetch_req} !== 4'b1010) begin errors++; $display("FAIL addw_rv32: got halt/cause/req %b exp 1010", {n_halt, n_halt_cause, n_ifetch_req}); end
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL addw_rv64_halt: got %b exp 0", halt); end
    @(negedge clk); #1;
    checks++; if (reg_wr !== 1'b1) begin errors++; $display("FAIL addw_wb: got %b exp 1", reg_wr); end
  endtask

  task automatic test_shift;
    do_reset();
    ifetch_ack = 1'b1; ifetch_data = I_SLLI32;
    @(negedge clk); ifetch_ack = 1'b0; #1;
    checks++; if ({alu_op, ext_op, word_op} !== {4'd3, 3'd2, 1'b0}) begin errors++; $display("FAIL slli32_decode: got op=%0d ext=%0d w=%b exp 3 2 0", alu_op, ext_op, word_op); end
    @(negedge clk); #1;
    checks++; if ({halt, n_halt, n_halt_cause} !== 4'b0101) begin errors++; $display("FAIL slli32_legal: got %b exp 0101", {halt, n_halt, n_halt_cause}); end
  endtask

  task automatic test_timeout;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      checks++; if ({ifetch_req, halt} !== 2'b10) begin errors++; $display("FAIL tmo_wait%0d: got req/halt %b exp 10", i, {ifetch_req, halt}); end
    end
    @(negedge clk); #1;
    checks++; if ({halt, halt_cause, ifetch_req} !== 4'b1100) begin errors++; $display("FAIL tmo_halt: got halt/cause/req %b exp 1100", {halt, halt_cause, ifetch_req}); end
    ifetch_ack = 1'b1; ifetch_data = I_ADDI;
    @(negedge clk); ifetch_ack = 1'b0; #1;
    checks++; if ({ir, halt} !== {32'h0, 1'b1}) begin errors++; $display("FAIL tmo_sticky: got ir=%h halt=%b exp 0 1", ir, halt); end
  endtask

  task automatic test_ack_at_limit;
    do_reset();
    for (int i = 0; i < 4; i++) @(negedge clk);
    ifetch_ack = 1'b1; ifetch_data = I_ADDI; #1;
    checks++; if (ifetch_req !== 1'b1) begin errors++; $display("FAIL limit_req: got %b exp 1", ifetch_req); end
    @(negedge clk); ifetch_ack = 1'b0; #1;
    checks++; if ({halt, ir} !== {1'b0, I_ADDI}) begin errors++; $display("FAIL limit_ack_wins: got halt=%b ir=%h exp 0 %h", halt, ir, I_ADDI); end
  endtask

  task automatic test_reset_mid_wait;
    do_reset();
    run_simple(I_ADDI);
    #1;
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL midrst_pre: got %0d exp 1", instret); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; ifetch_ack = 1'b1; ifetch_data = I_BEQ; #1;
    checks++; if ({ifetch_req, instret} !== {1'b0, 32'd0}) begin errors++; $display("FAIL midrst_abort: got req=%b instret=%0d exp 0 0", ifetch_req, instret); end
    @(negedge clk);
    rst = 1'b0; ifetch_ack = 1'b0; #1;
    checks++; if ({ifetch_req, halt, ir} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL midrst_fetch: got req=%b halt=%b ir=%h exp 1 0 0", ifetch_req, halt, ir); end
  endtask

  task automatic test_ebreak;
    do_reset();
    run_simple(I_ADDI);
    ifetch_ack = 1'b1; ifetch_data = I_EBREAK;
    @(negedge clk); ifetch_ack = 1'b0; #1;
    checks++; if ({reg_wr, pc_wr} !== 2'b00) begin errors++; $display("FAIL ebreak_decode: got %b exp 00", {reg_wr, pc_wr}); end
    @(negedge clk); #1;
    checks++; if ({halt, halt_cause} !== 3'b100) begin errors++; $display("FAIL ebreak_halt: got %b exp 100", {halt, halt_cause}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); ifetch_ack = 1'b1; dmem_ack = 1'b1; ifetch_data = I_ADDI; #1;
      checks++; if ({ifetch_req, dmem_req, reg_wr, pc_wr, halt, instret, ir} !== {5'b00001, 32'd1, I_EBREAK})
        begin errors++; $display("FAIL ebreak_ignore%0d: got req/dreq/rw/pw/halt %b instret=%0d ir=%h", i, {ifetch_req, dmem_req, reg_wr, pc_wr, halt}, instret, ir); end
    end
    ifetch_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic test_nop_illegal;
    do_reset();
    ifetch_ack = 1'b1; ifetch_data = I_ECALL;
    @(negedge clk); ifetch_ack = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if ({reg_wr, pc_wr, pc_sel, halt} !== 4'b0100) begin errors++; $display("FAIL ecall_wb: got %b exp 0100", {reg_wr, pc_wr, pc_sel, halt}); end
    @(negedge clk);
    ifetch_ack = 1'b1; ifetch_data = I_ZERO;
    @(negedge clk); ifetch_ack = 1'b0;
    @(negedge clk); #1;
    checks++; if ({halt, halt_cause, instret} !== {3'b101, 32'd1}) begin errors++; $display("FAIL illegal_halt: got halt/cause %b instret=%0d exp 101 1", {halt, halt_cause}, instret); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load();
    test_branch();
    test_word_ops();
    test_shift();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid_wait();
    test_ebreak();
    test_nop_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the NPC core. It replaces the single-cycle combinational decoder with an FSM that sequences FETCH, DECODE, EXEC, MEM and WB, and performs valid/ack handshakes with the instruction and data memory ports. It covers the full RV64I integer set, including loads, stores, conditional branches and the *W word ops. It holds the instruction register, counts retired instructions, and halts on ebreak, an illegal instruction or a bus timeout.

## Interface
- XLEN, 64: datapath width; only 64 (RV64I) and 32 (RV32I) are legal; with 32, *W and LD/SD/LWU decode as illegal.
- TIMEOUT, 255: maximum cycles to wait for an ack before a bus error; width is $clog2(TIMEOUT+1).
- CNT_W, 32: width of the retired-instruction counter.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ifetch_req  out  1  instruction fetch request.
- ifetch_ack  in  1  fetch data valid this cycle.
- ifetch_data  in  32  fetched instruction.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store.
- dmem_size  out  2  0 byte, 1 half, 2 word, 3 dword (func3[1:0]).
- dmem_unsigned  out  1  func3[2] for loads.
- dmem_ack  in  1  data access complete.
- br_taken  in  1  comparator result for a conditional branch, valid in EXEC.
- ir  out  32  latched instruction.
- alu_op  out  4  ALU operation: 0 add, 1 pass-B, 2 sub, 3 sll, 4 srl, 5 sra, 6 xor, 7 or, 8 and, 9 slt, 10 sltu.
- word_op  out  1  *W instruction (32-bit op, sign-extend result).
- ext_op  out  3  immediate format: 0 none, 1 R, 2 I, 3 S, 4 B, 5 U, 6 J.
- alu_a_sel  out  1  0 PC, 1 rs1.
- alu_b_sel  out  2  0 imm, 1 rs2, 2 constant 4.
- wb_sel  out  1  0 ALU result, 1 load data.
- branch  out  2  0 none, 1 jal, 2 jalr, 3 conditional.
- reg_wr  out  1  register-file write strobe.
- pc_wr  out  1  PC update strobe.
- pc_sel  out  1  0 PC+4, 1 ALU target; qualified by pc_wr.
- halt  out  1  core halted (sticky).
- halt_cause  out  2  0 ebreak, 1 illegal, 2 bus timeout.
- instret  out  CNT_W  retired-instruction count.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. The reset state is FETCH.
- FETCH
  - ifetch_req = 1 while in FETCH and rst = 0.
  - On ifetch_ack, ir <= ifetch_data and the FSM goes to DECODE.
- DECODE
  - Decode is combinational from ir; the control outputs are valid from DECODE through WB.
  - An illegal instruction sets halt_cause = 1 and goes to HALT.
  - ebreak (0x00100073) sets halt_cause = 0 and goes to HALT.
  - ecall, fence and fence.i decode as no-ops: no register write, PC+4.
- EXEC
  - Loads and stores go to MEM; everything else goes to WB.
  - For branch = 3, the FSM latches br_taken.
- MEM
  - dmem_req = 1 until dmem_ack, then the FSM goes to WB.
  - dmem_we, dmem_size and dmem_unsigned are held stable for the whole request.
- WB
  - reg_wr = 1 for R, I, U, J, jalr and load formats; reg_wr = 0 for S, B and no-ops. A write to rd = x0 still asserts reg_wr; the register file discards it.
  - pc_wr = 1 on every WB.
  - pc_sel = 1 for jal, jalr, or a conditional branch whose latched br_taken = 1.
  - instret increments by 1, wrapping modulo 2^CNT_W.
  - The next state is FETCH.
- Per-instruction decode:
  - lui: alu_op = 1, alu_b_sel = 0.
  - auipc: alu_op = 0, alu_a_sel = 0.
  - jal and jalr: the ALU computes PC+4 for the link (alu_a_sel = 0, alu_b_sel = 2). The target is computed by the external adder from ext_op.
  - Loads and stores: alu_op = 0, alu_a_sel = 1, alu_b_sel = 0.
  - Loads set wb_sel = 1.
  - Shifts use the shamt field: 6 bits for XLEN = 64, 5 bits for *W and XLEN = 32. A nonzero shamt[5] when XLEN = 32 is illegal.
- Timeout
  - A counter clears on entering FETCH or MEM and increments while waiting for an ack.
  - When the count reaches TIMEOUT with no ack, the FSM sets halt_cause = 2 and goes to HALT.
  - An ack arriving in the same cycle as the count reaching TIMEOUT wins; no timeout is raised.
- HALT: halt = 1; all requests and strobes are 0; the FSM leaves HALT only on rst.

## Timing
- Reset state: FSM in FETCH; ir = 0; instret = 0; halt = 0; halt_cause = 0; all strobes and requests 0. Requests are also forced to 0 asynchronously while rst = 1.
- Reset mid-operation aborts any pending handshake immediately. Any ack received afterwards is ignored.
- Minimum latency, with ack in the first request cycle:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load or store: 5 cycles (FETCH, DECODE, EXEC, MEM, WB).
- Each cycle of ack delay adds one cycle.
- A request is asserted from the cycle the FSM enters FETCH or MEM until the ack cycle inclusive, and drops the cycle after.
- An ack outside FETCH or MEM is ignored.
- reg_wr, pc_wr and the instret increment occur only in the single WB cycle.

## Test plan
- Reset, then addi x1, x0, 5 (0x00500093) acked immediately:
  - ifetch_req high in cycle 0.
  - In DECODE: alu_op = 0, ext_op = 2, alu_a_sel = 1, alu_b_sel = 0.
  - In cycle 3: reg_wr = 1, pc_wr = 1, pc_sel = 0.
  - instret = 1.
- ld x2, 8(x1) (0x0080B103) with dmem_ack delayed 3 cycles:
  - dmem_req high for 4 cycles with dmem_size = 3 and dmem_we = 0.
  - wb_sel = 1 and reg_wr = 1 in WB.
  - Total 8 cycles.
- beq (0x00208463) with br_taken = 1, then with br_taken = 0:
  - pc_sel = 1 in the taken case and 0 in the not-taken case.
  - reg_wr = 0 in both cases.
- addw (0x002080BB) gives word_op = 1 and alu_op = 0. The same encoding with XLEN = 32 gives halt = 1 and halt_cause = 1.
- ifetch_ack never asserted with TIMEOUT = 4:
  - halt = 1 and halt_cause = 2 after 5 FETCH cycles.
  - Asserting rst mid-wait instead returns the FSM to FETCH with instret = 0.
- ebreak:
  - halt = 1 and halt_cause = 0; no WB occurs and instret is unchanged.
  - Subsequent acks are ignored until rst.
